// File: rtl/accel_rd_arbiter_pkg.sv
// Shared types and constants for the two-requester AXI read arbiter.
// Holds the FSM encoding, AXI burst-type and default ID, and the arlen clamp helper.
package accel_rd_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [7:0] DEFAULT_ID = 8'h80;

   typedef struct packed {
      logic [7:0] len;
      logic       over;
   } len_chk_t;

   function automatic len_chk_t clamp_len(input logic [7:0] len, input logic [7:0] max_len);
      len_chk_t r;
      r.over = (len > max_len);
      r.len  = r.over ? max_len : len;
      return r;
   endfunction

endpackage

// File: rtl/accel_rd_arbiter_rr_arb2.sv
// Two-way round-robin grant, combinational grant; last winner updates when take is high.
// Zero latency; a held request simply waits, nothing is dropped.
module rr_arb2 (
   input  logic clk,
   input  logic rstn,
   input  logic req_a,
   input  logic req_b,
   input  logic take,
   output logic gnt_a,
   output logic gnt_b
);

   logic last_b;

   // On a tie the side that did not win last time goes first.
   always_comb begin
      gnt_a = req_a && (!req_b || last_b);
      gnt_b = req_b && !gnt_a;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         last_b <= 1'b1;
      end else if (take && (gnt_a || gnt_b)) begin
         last_b <= gnt_b;
      end
   end

endmodule

// File: rtl/accel_rd_arbiter.sv
// Arbitrates two burst loaders onto one AXI read port, one burst in flight; AR issues 1 cycle
// after acceptance, R beats are a combinational pass-through with requester rready as backpressure.
module accel_rd_arbiter
   import accel_rd_arbiter_pkg::*;
#(
   parameter int                  DATA_WIDTH = 256,
   parameter int                  ADDR_WIDTH = 32,
   parameter int                  ID_WIDTH   = 8,
   parameter logic [ID_WIDTH-1:0] ID         = ID_WIDTH'(DEFAULT_ID),
   parameter int                  MAX_LEN    = 15
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  req_a_valid,
   output logic                  req_a_ready,
   input  logic [ADDR_WIDTH-1:0] req_a_addr,
   input  logic [7:0]            req_a_len,
   output logic [DATA_WIDTH-1:0] a_rdata,
   output logic                  a_rvalid,
   output logic                  a_rlast,
   input  logic                  a_rready,
   input  logic                  req_b_valid,
   output logic                  req_b_ready,
   input  logic [ADDR_WIDTH-1:0] req_b_addr,
   input  logic [7:0]            req_b_len,
   output logic [DATA_WIDTH-1:0] b_rdata,
   output logic                  b_rvalid,
   output logic                  b_rlast,
   input  logic                  b_rready,
   output logic [ID_WIDTH-1:0]   axi_arid,
   output logic [ADDR_WIDTH-1:0] axi_araddr,
   output logic [7:0]            axi_arlen,
   output logic [2:0]            axi_arsize,
   output logic [1:0]            axi_arburst,
   output logic                  axi_arvalid,
   input  logic                  axi_arready,
   input  logic [ID_WIDTH-1:0]   axi_rid,
   input  logic [DATA_WIDTH-1:0] axi_rdata,
   input  logic [1:0]            axi_rresp,
   input  logic                  axi_rlast,
   input  logic                  axi_rvalid,
   output logic                  axi_rready,
   output logic                  busy,
   output logic                  err
);

   localparam logic [2:0] AR_SIZE   = 3'($clog2(DATA_WIDTH / 8));
   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [7:0]            len_q;
   logic [7:0]            cnt_q;
   logic                  sel_b_q;
   logic                  err_q;
   logic                  err_set;
   logic                  gnt_a, gnt_b;
   logic                  in_idle;
   logic                  beat;
   logic [7:0]            sel_len;
   len_chk_t              chk;

   assign in_idle = (state_q == ST_IDLE);
   assign beat    = (state_q == ST_DATA) && axi_rvalid && axi_rready;
   assign sel_len = gnt_b ? req_b_len : req_a_len;
   assign chk     = clamp_len(sel_len, MAX_LEN_B);

   rr_arb2 u_rr_arb2 (
      .clk   (clk),
      .rstn  (rstn),
      .req_a (req_a_valid),
      .req_b (req_b_valid),
      .take  (in_idle),
      .gnt_a (gnt_a),
      .gnt_b (gnt_b)
   );

   always_comb begin
      state_d     = state_q;
      req_a_ready = 1'b0;
      req_b_ready = 1'b0;
      axi_arvalid = 1'b0;
      axi_rready  = 1'b0;
      a_rvalid    = 1'b0;
      b_rvalid    = 1'b0;
      a_rlast     = 1'b0;
      b_rlast     = 1'b0;
      err_set     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_a_ready = gnt_a;
            req_b_ready = gnt_b;
            if (gnt_a || gnt_b) begin
               state_d = ST_ADDR;
               err_set = chk.over;
            end
         end
         ST_ADDR: begin
            axi_arvalid = 1'b1;
            if (axi_arready) state_d = ST_DATA;
         end
         ST_DATA: begin
            axi_rready = sel_b_q ? b_rready : a_rready;
            a_rvalid   = !sel_b_q && axi_rvalid;
            b_rvalid   = sel_b_q && axi_rvalid;
            a_rlast    = !sel_b_q && axi_rlast;
            b_rlast    = sel_b_q && axi_rlast;
            if (beat) begin
               // Bad ID/response or rlast out of step with the count flags err; rlast still ends the burst.
               if ((axi_rid != ID) || (axi_rresp != 2'b00)) err_set = 1'b1;
               if (axi_rlast != (cnt_q == len_q)) err_set = 1'b1;
               if (axi_rlast) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // AR fields read as zero whenever no address is being offered.
   assign axi_arid    = axi_arvalid ? ID : '0;
   assign axi_araddr  = axi_arvalid ? addr_q : '0;
   assign axi_arlen   = axi_arvalid ? len_q : '0;
   assign axi_arsize  = axi_arvalid ? AR_SIZE : '0;
   assign axi_arburst = axi_arvalid ? BURST_INCR : '0;
   assign a_rdata     = axi_rdata;
   assign b_rdata     = axi_rdata;
   assign busy        = !in_idle;
   assign err         = err_q;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         sel_b_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_q | err_set;
         if (in_idle && (gnt_a || gnt_b)) begin
            addr_q  <= gnt_b ? req_b_addr : req_a_addr;
            len_q   <= chk.len;
            sel_b_q <= gnt_b;
            cnt_q   <= '0;
         end else if (beat) begin
            cnt_q <= cnt_q + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_accel_rd_arbiter.sv
// Bench for accel_rd_arbiter: scenario tasks against a small grant/data reference model.
// An AXI slave is emulated inline; beats carry an address/index-derived pattern.
module tb_accel_rd_arbiter;

   localparam int DW = 256;
   localparam int AW = 32;
   localparam int IW = 8;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          req_a_valid = 1'b0, req_b_valid = 1'b0;
   logic          req_a_ready, req_b_ready;
   logic [AW-1:0] req_a_addr = '0, req_b_addr = '0;
   logic [7:0]    req_a_len = '0, req_b_len = '0;
   logic [DW-1:0] a_rdata, b_rdata;
   logic          a_rvalid, a_rlast, b_rvalid, b_rlast;
   logic          a_rready = 1'b0, b_rready = 1'b0;
   logic [IW-1:0] axi_arid;
   logic [AW-1:0] axi_araddr;
   logic [7:0]    axi_arlen;
   logic [2:0]    axi_arsize;
   logic [1:0]    axi_arburst;
   logic          axi_arvalid;
   logic          axi_arready = 1'b0;
   logic [IW-1:0] axi_rid = 8'h80;
   logic [DW-1:0] axi_rdata = '0;
   logic [1:0]    axi_rresp = 2'b00;
   logic          axi_rlast = 1'b0, axi_rvalid = 1'b0;
   logic          axi_rready;
   logic          busy, err;

   accel_rd_arbiter dut (
      .clk(clk), .rstn(rstn),
      .req_a_valid(req_a_valid), .req_a_ready(req_a_ready), .req_a_addr(req_a_addr), .req_a_len(req_a_len),
      .a_rdata(a_rdata), .a_rvalid(a_rvalid), .a_rlast(a_rlast), .a_rready(a_rready),
      .req_b_valid(req_b_valid), .req_b_ready(req_b_ready), .req_b_addr(req_b_addr), .req_b_len(req_b_len),
      .b_rdata(b_rdata), .b_rvalid(b_rvalid), .b_rlast(b_rlast), .b_rready(b_rready),
      .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
      .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
      .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
      .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_chk  = 0;

   // Reference model state: who won the last arbitration (reset: B).
   bit tb_last_b = 1'b1;

   // Observations gathered by the stimulus driver.
   logic          obs_gnt_a, obs_gnt_b, obs_busy_mid;
   int            obs_ar_lat, obs_xfers;
   logic [AW-1:0] obs_araddr;
   logic [7:0]    obs_arlen, obs_arid;
   logic [2:0]    obs_arsize;
   logic [1:0]    obs_arburst;
   logic [DW-1:0] obs_q[$];
   bit            obs_mirror_ok, obs_stall_ok, obs_other_blocked, obs_timeout, obs_aborted;

   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a, input int i);
      logic [31:0] w;
      w = (a + 32'(i) * 32'h0101_0001) ^ 32'(i << 20);
      return {8{w}};
   endfunction

   function automatic bit model_pick_b(input bit va, input bit vb);
      if (va && vb) return !tb_last_b;
      return vb;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0; req_a_valid = 1'b0; req_b_valid = 1'b0;
      axi_rvalid = 1'b0; axi_arready = 1'b0; a_rready = 1'b0; b_rready = 1'b0;
      tick();
      rstn = 1'b1;
      tb_last_b = 1'b1;
   endtask

   // Drives one request/burst; rr_mode 0=always ready, 1=toggle, 2=random.
   task automatic do_burst(input bit va, input bit vb, input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                           input logic [7:0] la, input logic [7:0] lb, input int nbeats, input int rr_mode,
                           input bit rv_rand, input bit ar_rand, input int bad_beat, input logic [1:0] bad_resp,
                           input logic [7:0] bad_rid, input int abort_beat);
      logic [AW-1:0] base;
      bit sel_b, hs, xfer;
      logic rr;
      int idx, cyc;
      obs_q.delete();
      obs_timeout = 0; obs_mirror_ok = 1; obs_stall_ok = 1; obs_other_blocked = 1;
      obs_ar_lat = -1; obs_xfers = 0; obs_aborted = 0;
      req_a_valid = va; req_b_valid = vb; req_a_addr = aa; req_b_addr = ab; req_a_len = la; req_b_len = lb;
      #1;
      obs_gnt_a = req_a_ready; obs_gnt_b = req_b_ready;
      if (obs_gnt_a === obs_gnt_b) begin
         obs_timeout = 1; req_a_valid = 0; req_b_valid = 0;
         return;
      end
      sel_b = obs_gnt_b;
      base = sel_b ? ab : aa;
      tick();
      if (sel_b) req_b_valid = 1'b0; else req_a_valid = 1'b0;
      obs_busy_mid = busy;
      hs = 0;
      for (int k = 0; k < 64 && !hs; k++) begin
         axi_arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         axi_rvalid = 1'b1; axi_rdata = pat(base, 0); axi_rlast = 1'b0; axi_rid = 8'h80; axi_rresp = 2'b00;
         #1;
         if (axi_rready !== 1'b0 || a_rvalid !== 1'b0 || b_rvalid !== 1'b0) obs_stall_ok = 0;
         if ((req_a_valid && req_a_ready) || (req_b_valid && req_b_ready)) obs_other_blocked = 0;
         if (axi_arvalid === 1'b1 && obs_ar_lat < 0) begin
            obs_ar_lat = k + 1; obs_araddr = axi_araddr; obs_arlen = axi_arlen;
            obs_arid = axi_arid; obs_arsize = axi_arsize; obs_arburst = axi_arburst;
         end
         hs = (axi_arvalid === 1'b1) && axi_arready;
         tick();
      end
      axi_arready = 1'b0; axi_rvalid = 1'b0;
      if (!hs) begin obs_timeout = 1; return; end
      idx = 0; cyc = 0;
      while (idx < nbeats && cyc < 2000) begin
         axi_rvalid = rv_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
         axi_rdata  = pat(base, idx);
         axi_rlast  = (idx == nbeats - 1);
         axi_rid    = (idx == bad_beat) ? bad_rid : 8'h80;
         axi_rresp  = (idx == bad_beat) ? bad_resp : 2'b00;
         case (rr_mode)
            0: rr = 1'b1;
            1: rr = (cyc % 2 == 0);
            default: rr = 1'($urandom_range(0, 1));
         endcase
         a_rready = rr; b_rready = rr;
         if (idx == abort_beat) begin
            axi_rvalid = 1'b1; rstn = 1'b0;
            tick();
            rstn = 1'b1; req_a_valid = 1'b0; req_b_valid = 1'b0;
            obs_aborted = 1; obs_xfers = idx; tb_last_b = 1'b1;
            return;
         end
         #1;
         if (axi_rready !== rr) obs_mirror_ok = 0;
         if ((sel_b ? b_rvalid : a_rvalid) !== axi_rvalid) obs_mirror_ok = 0;
         if ((sel_b ? a_rvalid : b_rvalid) !== 1'b0) obs_mirror_ok = 0;
         if ((req_a_valid && req_a_ready) || (req_b_valid && req_b_ready)) obs_other_blocked = 0;
         xfer = axi_rvalid && (axi_rready === 1'b1);
         if (sel_b ? (b_rvalid && b_rready) : (a_rvalid && a_rready))
            obs_q.push_back(sel_b ? b_rdata : a_rdata);
         tick();
         if (xfer) idx++;
         cyc++;
      end
      axi_rvalid = 1'b0; axi_rlast = 1'b0; a_rready = 1'b0; b_rready = 1'b0;
      if (idx < nbeats) obs_timeout = 1;
      obs_xfers = idx;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      tick();
      n_chk++; if (busy !== 1'b0) $display("FAIL reset busy got %b want 0", busy); else n_pass++;
      n_chk++; if (err !== 1'b0) $display("FAIL reset err got %b want 0", err); else n_pass++;
      n_chk++; if (axi_arvalid !== 1'b0) $display("FAIL reset arvalid got %b want 0", axi_arvalid); else n_pass++;
      n_chk++; if (axi_rready !== 1'b0) $display("FAIL reset rready got %b want 0", axi_rready); else n_pass++;
      n_chk++; if ({req_a_ready, req_b_ready, a_rvalid, b_rvalid, a_rlast, b_rlast} !== 6'b0)
         $display("FAIL reset req/r flags got %b want 000000", {req_a_ready, req_b_ready, a_rvalid, b_rvalid, a_rlast, b_rlast}); else n_pass++;
      n_chk++; if ({axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst} !== '0)
         $display("FAIL reset ar fields got %h want 0", {axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst}); else n_pass++;
      rstn = 1'b1;
      tb_last_b = 1'b1;
   endtask

   task automatic test_single_a();
      int bad = 0;
      bit eb = model_pick_b(1, 0);
      do_burst(1, 0, 32'h4, 32'h0, 8'd7, 8'd0, 8, 0, 0, 0, -1, 2'b00, 8'h80, -1);
      tb_last_b = eb;
      n_chk++; if (obs_timeout) $display("FAIL single timeout got 1 want 0"); else n_pass++;
      n_chk++; if ({obs_gnt_a, obs_gnt_b} !== 2'b10) $display("FAIL single grant got %b want 10", {obs_gnt_a, obs_gnt_b}); else n_pass++;
      n_chk++; if (obs_ar_lat != 1) $display("FAIL single ar latency got %0d want 1", obs_ar_lat); else n_pass++;
      n_chk++; if (obs_araddr !== 32'h4) $display("FAIL single araddr got %h want 4", obs_araddr); else n_pass++;
      n_chk++; if (obs_arlen !== 8'd7) $display("FAIL single arlen got %0d want 7", obs_arlen); else n_pass++;
      n_chk++; if (obs_arsize !== 3'd5) $display("FAIL single arsize got %0d want 5", obs_arsize); else n_pass++;
      n_chk++; if (obs_arburst !== 2'b01 || obs_arid !== 8'h80)
         $display("FAIL single arburst/arid got %b/%h want 01/80", obs_arburst, obs_arid); else n_pass++;
      n_chk++; if (obs_busy_mid !== 1'b1) $display("FAIL single busy mid got %b want 1", obs_busy_mid); else n_pass++;
      n_chk++; if (obs_q.size() != 8) $display("FAIL single beats got %0d want 8", obs_q.size()); else n_pass++;
      for (int i = 0; i < obs_q.size(); i++) if (obs_q[i] !== pat(32'h4, i)) bad++;
      n_chk++; if (bad != 0) $display("FAIL single data got %0d bad beats want 0", bad); else n_pass++;
      n_chk++; if (busy !== 1'b0) $display("FAIL single busy after got %b want 0", busy); else n_pass++;
      n_chk++; if (!obs_stall_ok || !obs_mirror_ok) $display("FAIL single routing got stall=%0d mirror=%0d want 1/1", obs_stall_ok, obs_mirror_ok); else n_pass++;
      n_chk++; if (err !== 1'b0) $display("FAIL single err got %b want 0", err); else n_pass++;
   endtask

   task automatic test_tie();
      bit tva[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      do_reset();
      for (int t = 0; t < 4; t++) begin
         int bad = 0;
         logic [AW-1:0] aa = 32'h100 * (t + 1), ab = 32'h100 * (t + 1) + 32'h40;
         bit eb = model_pick_b(tva[t], 1'b1);
         do_burst(tva[t], 1'b1, aa, ab, 8'd3, 8'd3, 4, 0, 1, 1, -1, 2'b00, 8'h80, -1);
         tb_last_b = eb;
         n_chk++; if (obs_gnt_b !== eb || obs_gnt_a !== !eb)
            $display("FAIL tie%0d grant got a=%b b=%b want b=%b", t, obs_gnt_a, obs_gnt_b, eb); else n_pass++;
         for (int i = 0; i < obs_q.size(); i++) if (obs_q[i] !== pat(eb ? ab : aa, i)) bad++;
         n_chk++; if (bad != 0 || obs_q.size() != 4 || obs_timeout)
            $display("FAIL tie%0d data got %0d beats %0d bad want 4 0", t, obs_q.size(), bad); else n_pass++;
         n_chk++; if (!obs_other_blocked) $display("FAIL tie%0d pending ready while busy got 1 want 0", t); else n_pass++;
      end
      req_a_valid = 1'b0; req_b_valid = 1'b0;
   endtask

   task automatic test_toggle();
      int bad = 0;
      do_reset();
      do_burst(1, 0, 32'h1000, 32'h0, 8'd15, 8'd0, 16, 1, 1, 0, -1, 2'b00, 8'h80, -1);
      tb_last_b = 1'b0;
      n_chk++; if (obs_xfers != 16 || obs_q.size() != 16)
         $display("FAIL toggle beats got %0d/%0d want 16", obs_xfers, obs_q.size()); else n_pass++;
      for (int i = 0; i < obs_q.size(); i++) if (obs_q[i] !== pat(32'h1000, i)) bad++;
      n_chk++; if (bad != 0) $display("FAIL toggle order got %0d bad beats want 0", bad); else n_pass++;
      n_chk++; if (!obs_mirror_ok) $display("FAIL toggle rready mirror got 0 want 1"); else n_pass++;
   endtask

   task automatic test_errors();
      do_reset();
      do_burst(1, 0, 32'h40, 32'h0, 8'd7, 8'd0, 8, 0, 0, 0, 3, 2'b10, 8'h80, -1);
      n_chk++; if (err !== 1'b1 || obs_xfers != 8) $display("FAIL rresp err got %b beats %0d want 1 8", err, obs_xfers); else n_pass++;
      do_burst(0, 1, 32'h0, 32'h80, 8'd0, 8'd1, 2, 0, 0, 0, -1, 2'b00, 8'h80, -1);
      n_chk++; if (err !== 1'b1) $display("FAIL err sticky got %b want 1", err); else n_pass++;
      do_reset();
      do_burst(1, 0, 32'h60, 32'h0, 8'd7, 8'd0, 8, 0, 0, 0, 2, 2'b00, 8'h81, -1);
      n_chk++; if (err !== 1'b1 || obs_xfers != 8) $display("FAIL rid err got %b beats %0d want 1 8", err, obs_xfers); else n_pass++;
      do_reset();
      do_burst(1, 0, 32'h80, 32'h0, 8'd7, 8'd0, 4, 0, 0, 0, -1, 2'b00, 8'h80, -1);
      n_chk++; if (err !== 1'b1 || busy !== 1'b0 || obs_xfers != 4)
         $display("FAIL early rlast got err=%b busy=%b beats=%0d want 1 0 4", err, busy, obs_xfers); else n_pass++;
   endtask

   task automatic test_clamp();
      do_reset();
      do_burst(1, 0, 32'h200, 32'h0, 8'd20, 8'd0, 16, 0, 0, 0, -1, 2'b00, 8'h80, -1);
      tb_last_b = 1'b0;
      n_chk++; if (obs_arlen !== 8'd15) $display("FAIL clamp arlen got %0d want 15", obs_arlen); else n_pass++;
      n_chk++; if (err !== 1'b1) $display("FAIL clamp err got %b want 1", err); else n_pass++;
   endtask

   task automatic test_midreset();
      do_reset();
      do_burst(1, 0, 32'h2000, 32'h0, 8'd20, 8'd0, 16, 0, 0, 0, -1, 2'b00, 8'h80, 4);
      n_chk++; if (!obs_aborted || busy !== 1'b0 || axi_arvalid !== 1'b0 || axi_rready !== 1'b0 || a_rvalid !== 1'b0)
         $display("FAIL midreset state got ab=%0d busy=%b arv=%b rr=%b arv_a=%b want 1 0 0 0 0", obs_aborted, busy, axi_arvalid, axi_rready, a_rvalid); else n_pass++;
      n_chk++; if (err !== 1'b0) $display("FAIL midreset err got %b want 0", err); else n_pass++;
      axi_rvalid = 1'b0;
      do_burst(1, 0, 32'h3000, 32'h0, 8'd3, 8'd0, 4, 0, 0, 0, -1, 2'b00, 8'h80, -1);
      tb_last_b = 1'b0;
      n_chk++; if (obs_gnt_a !== 1'b1 || obs_xfers != 4 || err !== 1'b0)
         $display("FAIL midreset fresh got gnt=%b beats=%0d err=%b want 1 4 0", obs_gnt_a, obs_xfers, err); else n_pass++;
   endtask

   task automatic test_random();
      do_reset();
      for (int t = 0; t < 12; t++) begin
         int bad = 0;
         bit va = 1'($urandom_range(0, 1)), vb = 1'($urandom_range(0, 1));
         logic [AW-1:0] aa = $urandom & 32'hFFFF_FFE0, ab = $urandom & 32'hFFFF_FFE0;
         logic [7:0] la = 8'($urandom_range(0, 15)), lb = 8'($urandom_range(0, 15));
         bit eb;
         if (!va && !vb) va = 1'b1;
         eb = model_pick_b(va, vb);
         do_burst(va, vb, aa, ab, la, lb, int'(eb ? lb : la) + 1, 2, 1, 1, -1, 2'b00, 8'h80, -1);
         tb_last_b = eb;
         n_chk++; if (obs_gnt_b !== eb || obs_araddr !== (eb ? ab : aa) || obs_arlen !== (eb ? lb : la))
            $display("FAIL rand%0d ar got b=%b addr=%h len=%0d want b=%b addr=%h len=%0d", t, obs_gnt_b, obs_araddr, obs_arlen, eb, eb ? ab : aa, eb ? lb : la); else n_pass++;
         for (int i = 0; i < obs_q.size(); i++) if (obs_q[i] !== pat(eb ? ab : aa, i)) bad++;
         n_chk++; if (bad != 0 || obs_q.size() != int'(eb ? lb : la) + 1 || !obs_mirror_ok || obs_timeout)
            $display("FAIL rand%0d data got %0d beats %0d bad want %0d 0", t, obs_q.size(), bad, int'(eb ? lb : la) + 1); else n_pass++;
         req_a_valid = 1'b0; req_b_valid = 1'b0;
      end
      n_chk++; if (err !== 1'b0) $display("FAIL rand err got %b want 0", err); else n_pass++;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_a();
      test_tie();
      test_toggle();
      test_errors();
      test_clamp();
      test_midreset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/accel_rd_arbiter.md
ACCEL_RD_ARBITER -- requirements
Module: accel_rd_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 256: AXI read-data and requester data width in bits.
REQ-002 Parameter ADDR_WIDTH, default 32: AXI address width.
REQ-003 Parameter ID_WIDTH, default 8: AXI ID width.
REQ-004 Parameter ID, default 8'h80: fixed ARID driven on every burst and expected on RID.
REQ-005 Parameter MAX_LEN, default 15: largest legal arlen value (16 beats).
REQ-006 The design SHALL use one clock; reset is synchronous and active-low.
REQ-007 The port list SHALL be as follows (clock and reset first):
- clk  in  1  system clock; all logic on rising edge.
- rstn  in  1  synchronous active-low reset.
- req_a_valid / req_a_ready  in/out  1/1  requester A (matrix A loader) burst request handshake.
- req_a_addr / req_a_len  in  ADDR_WIDTH/8  A: burst byte address; beats minus 1.
- a_rdata / a_rvalid / a_rlast / a_rready  out/out/out/in  DATA_WIDTH/1/1/1  A: returned beat stream.
- req_b_*, b_r*  same as A  -  requester B (matrix B loader).
- axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid / axi_arready  out.../in  ID_WIDTH, ADDR_WIDTH, 8, 3, 2, 1/1  AXI AR channel.
- axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid / axi_rready  in.../out  ID_WIDTH, DATA_WIDTH, 2, 1, 1/1  AXI R channel.
- busy  out  1  high whenever the state is not IDLE.
- err  out  1  sticky error flag.

Function
REQ-008 The FSM SHALL have states IDLE, ADDR, DATA; at most one burst outstanding.
REQ-009 In IDLE with any req_x_valid, the arbiter SHALL grant one requester, assert its req_x_ready combinationally that cycle, latch addr/len, and go to ADDR.
REQ-010 When both requests are valid, the grant SHALL go to the requester not granted last (round-robin); last_grant resets to B so A wins the first tie.
REQ-011 In ADDR, axi_arvalid SHALL be 1 with the latched araddr/arlen held stable until axi_arready; on handshake the FSM SHALL go to DATA; AR latency is 1 cycle after request acceptance.
REQ-012 axi_arid SHALL equal ID, axi_arsize SHALL equal log2(DATA_WIDTH/8) (5 at default), and axi_arburst SHALL be 2'b01 (INCR).
REQ-013 A req_len above MAX_LEN SHALL be clamped to MAX_LEN and SHALL set err.
REQ-014 In DATA, the R channel SHALL be a combinational pass-through to the granted requester: x_rvalid=axi_rvalid, x_rdata=axi_rdata, x_rlast=axi_rlast, axi_rready=x_rready; the other requester's rvalid SHALL be 0.
REQ-015 A beat SHALL transfer on axi_rvalid&axi_rready; the FSM SHALL go to IDLE on the beat with axi_rlast=1; a new grant is possible in the next cycle.
REQ-016 axi_rready SHALL be 0 outside DATA; R beats arriving in IDLE/ADDR SHALL stall and not be routed.
REQ-017 On a transferred beat, axi_rid!=ID or axi_rresp!=0 SHALL set err, and the beat SHALL still be delivered.
REQ-018 The design SHALL count beats internally; an early rlast or missing rlast at count=arlen SHALL set err, and rlast alone SHALL still terminate the burst.
REQ-019 A request arriving while busy SHALL see req_x_ready=0 and stay pending without loss.

Reset
REQ-020 When rstn=0 at a clock edge, the design SHALL enter IDLE with axi_arvalid, axi_rready, req_x_ready, x_rvalid, x_rlast, busy and err all 0, the AR fields 0, and last_grant=B.
REQ-021 Reset asserted mid-burst SHALL abandon the burst with no completion signalled; requesters are reset by the same rstn.

Structure
REQ-022 The shared package SHALL hold the FSM state encoding, the AXI burst-type constant INCR=2'b01, and the default ID 8'h80.
REQ-023 The round-robin grant logic SHALL be one sub-module, rr_arb2.

Verification
REQ-024 The bench SHALL cover:
- Single A request addr=0x4, len=7, arready=1 -> arvalid 1 cycle after req_a_ready, araddr=0x4, arlen=7, arsize=5, 8 beats to A, busy falls after beat 8.
- A and B valid simultaneously after reset -> A granted first, then B; a later tie goes to the granted-last opposite.
- Requester rready toggled 1/0 every cycle during a 16-beat burst -> all 16 beats delivered in order, none duplicated, axi_rready mirrors rready.
- rresp=2'b10 on beat 3, or rid=0x81 -> err set and sticky, burst still completes.
- req_len=20 -> arlen=15, err=1.
- rstn low during beat 5 of a burst -> next cycle IDLE, arvalid=0, rready=0, err=0, a fresh request is accepted.
